// File: rtl/seq_detect_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detect_if
//  Description : Bus bundle for seq_detect_param: the serial data input, the
//                configuration fields, the counter clear and the detector
//                results.
//  Ports       : master drives a, a_en, cfg_*, cnt_clr and observes valid,
//                match_count, fill. slave is the detector side.
//  Options     : SEQ_DETECT_MASK_EN adds cfg_mask (PAT_W bits).
//  Revision    : 1.0 - initial release
// ============================================================================
interface seq_detect_if #(
   parameter int PAT_W = 8,
   parameter int CNT_W = 8,
   parameter int LEN_W = $clog2(PAT_W + 1)
);
   logic             a;
   logic             a_en;
   logic             cfg_load;
   logic [PAT_W-1:0] cfg_pattern;
   logic [LEN_W-1:0] cfg_len;
   logic             cfg_overlap;
`ifdef SEQ_DETECT_MASK_EN
   logic [PAT_W-1:0] cfg_mask;
`endif
   logic             cnt_clr;
   logic             valid;
   logic [CNT_W-1:0] match_count;
   logic [LEN_W-1:0] fill;

   modport master (
      output a, a_en, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
`ifdef SEQ_DETECT_MASK_EN
      output cfg_mask,
`endif
      output cnt_clr,
      input  valid, match_count, fill
   );

   modport slave (
      input  a, a_en, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
`ifdef SEQ_DETECT_MASK_EN
      input  cfg_mask,
`endif
      input  cnt_clr,
      output valid, match_count, fill
   );
endinterface
`default_nettype wire

// File: rtl/seq_detect_param.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detect_param
//  Description : Runtime-programmable serial sequence detector. Pattern of
//                length 1..PAT_W, overlapping or non-overlapping matching,
//                input qualifier strobe and saturating match counter.
//  Ports       : clk   - clock, rising edge
//                reset - synchronous active-high reset
//                bus   - seq_detect_if.slave:
//                        a, a_en             serial bit and its qualifier
//                        cfg_load            latches cfg_pattern/len/overlap
//                        cnt_clr             clears match_count
//                        valid               one-cycle pulse per match
//                        match_count         saturating match count
//                        fill                usable history bits (<= PAT_W)
//  Options     : SEQ_DETECT_MASK_EN adds cfg_mask; a set bit k makes pattern
//                position k a don't-care.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_detect_param #(
   parameter int PAT_W = 8,
   parameter int CNT_W = 8,
   parameter int LEN_W = $clog2(PAT_W + 1)
) (
   input  logic        clk,
   input  logic        reset,
   seq_detect_if.slave bus
);

   localparam logic [LEN_W-1:0] c_len_max = LEN_W'(PAT_W);

   logic [PAT_W-1:0] r_hist;
   logic [LEN_W-1:0] r_fill;
   logic [PAT_W-1:0] r_pat;
   logic [LEN_W-1:0] r_len;
   logic             r_overlap;
   logic             r_valid;
   logic [CNT_W-1:0] r_count;

   logic [PAT_W-1:0] w_hist_next;
   logic [LEN_W-1:0] w_fill_next;
   logic [PAT_W-1:0] w_mask;
   logic [PAT_W:0]   w_len_hit;
   logic             w_enabled;
   logic             w_match;

`ifdef SEQ_DETECT_MASK_EN
   logic [PAT_W-1:0] r_mask;
   assign w_mask = r_mask;
`else
   assign w_mask = '0;
`endif

   // Newest bit enters at position 0
   assign w_hist_next = {r_hist[PAT_W-2:0], bus.a};
   assign w_fill_next = (r_fill >= c_len_max) ? c_len_max : r_fill + 1'b1;

   // For every candidate length l, precompute whether the last l bits of the
   // updated history equal pattern[l-1:0] with pattern bit 0 being the oldest
   // of those l bits. The latched length then just selects one result, which
   // keeps all bit indices compile-time constant.
   assign w_len_hit[0] = 1'b0;
   genvar gl, gk;
   generate
      for (gl = 1; gl <= PAT_W; gl++) begin : g_len
         logic [gl-1:0] w_eq;
         for (gk = 0; gk < gl; gk++) begin : g_bit
            assign w_eq[gk] = (w_hist_next[gl-1-gk] == r_pat[gk]) | w_mask[gk];
         end
         assign w_len_hit[gl] = &w_eq;
      end
   endgenerate

   assign w_enabled = (r_len != '0) && (r_len <= c_len_max);

   // A bit arriving together with cfg_load is discarded, so it cannot match
   assign w_match = bus.a_en && !bus.cfg_load && w_enabled &&
                    (w_fill_next >= r_len) && w_len_hit[r_len];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_hist    <= '0;
         r_fill    <= '0;
         r_pat     <= '0;
         r_len     <= '0;
         r_overlap <= 1'b0;
         r_valid   <= 1'b0;
         r_count   <= '0;
`ifdef SEQ_DETECT_MASK_EN
         r_mask    <= '0;
`endif
      end else begin
         r_valid <= 1'b0;
         if (bus.cfg_load) begin
            r_pat     <= bus.cfg_pattern;
            r_len     <= bus.cfg_len;
            r_overlap <= bus.cfg_overlap;
`ifdef SEQ_DETECT_MASK_EN
            r_mask    <= bus.cfg_mask;
`endif
            r_hist    <= '0;
            r_fill    <= '0;
         end else if (bus.a_en) begin
            r_hist  <= w_hist_next;
            // Non-overlapping mode restarts the fill so the next match needs
            // a complete set of fresh bits
            r_fill  <= (w_match && !r_overlap) ? '0 : w_fill_next;
            r_valid <= w_match;
         end

         // Clear-then-count when both happen on the same edge
         if (w_match) begin
            if (bus.cnt_clr) begin
               r_count <= CNT_W'(1);
            end else if (!(&r_count)) begin
               r_count <= r_count + 1'b1;
            end
         end else if (bus.cnt_clr) begin
            r_count <= '0;
         end
      end
   end

   assign bus.valid       = r_valid;
   assign bus.match_count = r_count;
   assign bus.fill        = r_fill;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_detect_param
//  Description : Directed self-checking bench for seq_detect_param. Two
//                instances share the stimulus: dut8 (CNT_W=8) and dut2
//                (CNT_W=2, used for counter saturation).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detect_param;

   localparam int PAT_W = 8;
   localparam int LEN_W = $clog2(PAT_W + 1);

   logic             clk = 1'b0;
   logic             reset;
   logic             a, a_en, cfg_load, cfg_overlap, cnt_clr;
   logic [PAT_W-1:0] cfg_pattern;
   logic [LEN_W-1:0] cfg_len;
`ifdef SEQ_DETECT_MASK_EN
   logic [PAT_W-1:0] cfg_mask;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   seq_detect_if #(.PAT_W(PAT_W), .CNT_W(8)) bus8 ();
   seq_detect_if #(.PAT_W(PAT_W), .CNT_W(2)) bus2 ();

   assign bus8.a = a;               assign bus2.a = a;
   assign bus8.a_en = a_en;         assign bus2.a_en = a_en;
   assign bus8.cfg_load = cfg_load; assign bus2.cfg_load = cfg_load;
   assign bus8.cfg_pattern = cfg_pattern; assign bus2.cfg_pattern = cfg_pattern;
   assign bus8.cfg_len = cfg_len;   assign bus2.cfg_len = cfg_len;
   assign bus8.cfg_overlap = cfg_overlap; assign bus2.cfg_overlap = cfg_overlap;
   assign bus8.cnt_clr = cnt_clr;   assign bus2.cnt_clr = cnt_clr;
`ifdef SEQ_DETECT_MASK_EN
   assign bus8.cfg_mask = cfg_mask; assign bus2.cfg_mask = cfg_mask;
`endif

   seq_detect_param #(.PAT_W(PAT_W), .CNT_W(8)) dut8 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus8.slave)
   );

   seq_detect_param #(.PAT_W(PAT_W), .CNT_W(2)) dut2 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus2.slave)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock: drive at the falling edge, sample 1 time unit after rising edge
   task automatic step(input logic b, input logic en, input logic ld, input logic clr);
      @(negedge clk);
      a = b; a_en = en; cfg_load = ld; cnt_clr = clr;
      @(posedge clk);
      #1;
      a_en = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
   endtask

   task automatic bit_in(input logic b, input logic exp_v, input string tag);
      step(b, 1'b1, 1'b0, 1'b0);
      chk(tag, 32'(bus8.valid), 32'(exp_v));
   endtask

   task automatic load(input logic [PAT_W-1:0] pat, input logic [LEN_W-1:0] len,
                       input logic ov);
      cfg_pattern = pat; cfg_len = len; cfg_overlap = ov;
      step(1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic clear_cnt();
      step(1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      reset = 1'b1; a = 1'b0; a_en = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
      cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
`ifdef SEQ_DETECT_MASK_EN
      cfg_mask = '0;
`endif
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(bus8.valid), 0);
      chk("rst_count", 32'(bus8.match_count), 0);
      chk("rst_fill",  32'(bus8.fill), 0);
      @(negedge clk); reset = 1'b0;

      // 1: single match of 1,0,1,1, non-overlapping
      load(8'b0000_1101, 4'd4, 1'b0);
      bit_in(1, 0, "t1_b1");
      chk("t1_fill1", 32'(bus8.fill), 1);
      bit_in(0, 0, "t1_b2");
      bit_in(1, 0, "t1_b3");
      bit_in(1, 1, "t1_b4");
      chk("t1_count", 32'(bus8.match_count), 1);
      chk("t1_fill_after", 32'(bus8.fill), 0);
      step(0, 0, 0, 0);
      chk("t1_pulse_end", 32'(bus8.valid), 0);

      // 2: 1,0,1,1,0,1,1 non-overlapping then overlapping
      clear_cnt();
      chk("t2_clr", 32'(bus8.match_count), 0);
      load(8'b0000_1101, 4'd4, 1'b0);
      bit_in(1, 0, "t2a_b1"); bit_in(0, 0, "t2a_b2"); bit_in(1, 0, "t2a_b3");
      bit_in(1, 1, "t2a_b4"); bit_in(0, 0, "t2a_b5"); bit_in(1, 0, "t2a_b6");
      bit_in(1, 0, "t2a_b7");
      chk("t2a_count", 32'(bus8.match_count), 1);
      clear_cnt();
      load(8'b0000_1101, 4'd4, 1'b1);
      bit_in(1, 0, "t2b_b1"); bit_in(0, 0, "t2b_b2"); bit_in(1, 0, "t2b_b3");
      bit_in(1, 1, "t2b_b4"); bit_in(0, 0, "t2b_b5"); bit_in(1, 0, "t2b_b6");
      bit_in(1, 1, "t2b_b7");
      chk("t2b_count", 32'(bus8.match_count), 2);

      // 3: 1,1,1 against six 1s
      clear_cnt();
      load(8'b0000_0111, 4'd3, 1'b1);
      bit_in(1, 0, "t3a_b1"); bit_in(1, 0, "t3a_b2"); bit_in(1, 1, "t3a_b3");
      bit_in(1, 1, "t3a_b4"); bit_in(1, 1, "t3a_b5"); bit_in(1, 1, "t3a_b6");
      chk("t3a_count", 32'(bus8.match_count), 4);
      clear_cnt();
      load(8'b0000_0111, 4'd3, 1'b0);
      bit_in(1, 0, "t3b_b1"); bit_in(1, 0, "t3b_b2"); bit_in(1, 1, "t3b_b3");
      bit_in(1, 0, "t3b_b4"); bit_in(1, 0, "t3b_b5"); bit_in(1, 1, "t3b_b6");
      chk("t3b_count", 32'(bus8.match_count), 2);

      // 4: gated cycles between sampled bits
      clear_cnt();
      load(8'b0000_1101, 4'd4, 1'b0);
      bit_in(1, 0, "t4_b1"); bit_in(0, 0, "t4_b2");
      step(1, 0, 0, 0); chk("t4_gate1", 32'(bus8.valid), 0);
      step(0, 0, 0, 0); chk("t4_gate2", 32'(bus8.valid), 0);
      step(1, 0, 0, 0); chk("t4_gate3", 32'(bus8.valid), 0);
      chk("t4_fill_hold", 32'(bus8.fill), 2);
      bit_in(1, 0, "t4_b3"); bit_in(1, 1, "t4_b4");
      chk("t4_count", 32'(bus8.match_count), 1);

      // 5: saturation of the 2-bit counter, clear coincident with a match
      clear_cnt();
      load(8'b0000_0001, 4'd1, 1'b1);
      bit_in(1, 1, "t5_m1"); bit_in(1, 1, "t5_m2"); bit_in(1, 1, "t5_m3");
      chk("t5_cnt2_3", 32'(bus2.match_count), 3);
      bit_in(1, 1, "t5_m4"); bit_in(1, 1, "t5_m5");
      chk("t5_cnt2_sat", 32'(bus2.match_count), 3);
      chk("t5_cnt8_5", 32'(bus8.match_count), 5);
      chk("t5_fill5", 32'(bus8.fill), 5);
      step(1, 1, 0, 1);
      chk("t5_clr_match2", 32'(bus2.match_count), 1);
      chk("t5_clr_match8", 32'(bus8.match_count), 1);
      chk("t5_clr_valid", 32'(bus8.valid), 1);
      bit_in(0, 0, "t5_nm"); bit_in(1, 1, "t5_m7"); bit_in(1, 1, "t5_m8");
      chk("t5_fill_sat", 32'(bus8.fill), 8);
      chk("t5_cnt8_3", 32'(bus8.match_count), 3);
      clear_cnt();
      chk("t5_clr_only", 32'(bus2.match_count), 0);
      chk("t5_clr_fill", 32'(bus8.fill), 8);

      // Full-length pattern 1,0,1,0,0,1,0,1
      load(8'b1010_0101, 4'd8, 1'b0);
      bit_in(1, 0, "tf_b1"); bit_in(0, 0, "tf_b2"); bit_in(1, 0, "tf_b3");
      bit_in(0, 0, "tf_b4"); bit_in(0, 0, "tf_b5"); bit_in(1, 0, "tf_b6");
      bit_in(0, 0, "tf_b7"); bit_in(1, 1, "tf_b8");

      // 6: reset mid-sequence, then only the last bit
      load(8'b0000_1101, 4'd4, 1'b0);
      bit_in(1, 0, "t6_b1"); bit_in(0, 0, "t6_b2"); bit_in(1, 0, "t6_b3");
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      chk("t6_rst_fill", 32'(bus8.fill), 0);
      chk("t6_rst_count", 32'(bus8.match_count), 0);
      @(negedge clk); reset = 1'b0;
      bit_in(1, 0, "t6_disabled");
      // cfg_load with a qualified bit on the same edge: bit discarded
      cfg_pattern = 8'b0000_1101; cfg_len = 4'd4; cfg_overlap = 1'b0;
      step(1, 1, 1, 0);
      chk("t6_ld_valid", 32'(bus8.valid), 0);
      chk("t6_ld_fill", 32'(bus8.fill), 0);
      bit_in(1, 0, "t6_last");
      // Length 0 disables matching; history and fill still advance
      load(8'b0000_0000, 4'd0, 1'b1);
      bit_in(0, 0, "t6z_b1"); bit_in(0, 0, "t6z_b2"); bit_in(1, 0, "t6z_b3");
      bit_in(1, 0, "t6z_b4"); bit_in(0, 0, "t6z_b5"); bit_in(0, 0, "t6z_b6");
      chk("t6z_fill", 32'(bus8.fill), 6);
      // Length above PAT_W also disables
      load(8'b0000_0000, 4'd9, 1'b1);
      for (int i = 0; i < 9; i++) bit_in(0, 0, "t6big");
      chk("t6big_count", 32'(bus8.match_count), 0);

`ifdef SEQ_DETECT_MASK_EN
      cfg_mask = 8'b0000_0010;
      load(8'b0000_1101, 4'd4, 1'b0);
      bit_in(1, 0, "tm_a1"); bit_in(0, 0, "tm_a2"); bit_in(1, 0, "tm_a3");
      bit_in(1, 1, "tm_a4");
      bit_in(1, 0, "tm_b1"); bit_in(1, 0, "tm_b2"); bit_in(1, 0, "tm_b3");
      bit_in(1, 1, "tm_b4");
      chk("tm_count", 32'(bus8.match_count), 2);
      cfg_mask = '0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
Parametrised serial sequence detector. Generalises the fixed 4-bit `seqDetect` to a runtime-programmable pattern of length 1..PAT_W, with overlapping or non-overlapping match modes, an input-qualifier strobe and a saturating match counter. It sits on a serial data path and raises a one-cycle `valid` pulse for each detected occurrence.

Parameters:
- PAT_W, 8: maximum pattern length in bits; legal range 2..32.
- CNT_W, 8: width of the match counter.
- LEN_W, $clog2(PAT_W+1): width of the length fields; derived, do not override.

Ports:
- clk, input, 1: clock; all logic on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- a, input, 1: serial data bit.
- a_en, input, 1: `a` is sampled only on cycles where a_en=1.
- cfg_load, input, 1: one-cycle strobe that latches cfg_pattern, cfg_len and cfg_overlap.
- cfg_pattern, input, PAT_W: pattern bits; bit 0 is the first bit of the sequence in time.
- cfg_len, input, LEN_W: pattern length.
- cfg_overlap, input, 1: 1 selects overlapping matches; 0 selects non-overlapping.
- cnt_clr, input, 1: synchronous clear of match_count.
- valid, output, 1: one-cycle pulse per detected match.
- match_count, output, CNT_W: saturating count of matches.
- fill, output, LEN_W: number of history bits currently usable for a match, saturating at PAT_W.

Behaviour:
- Reset (reset=1 at a clock edge) clears: valid=0, match_count=0, fill=0, history=0, latched pattern=0, latched len=0 (detector disabled), latched overlap=0. Reset overrides all other inputs.
- History register `hist` is PAT_W bits. On an edge with a_en=1: hist <= {hist[PAT_W-2:0], a}, so the newest bit is at hist[0]. When a_en=0, hist and fill hold.
- Match condition for L = latched len, evaluated on the updated history: a_en=1, and 1 <= L <= PAT_W, and fill_next >= L, and hist_next[L-1-k] == pattern[k] for every k in 0..L-1.
- Latency: `valid` is registered. It is high for exactly the one cycle following the edge that samples the completing bit. No combinational path from `a` to `valid`.
- fill_next = min(fill+1, PAT_W) on each sampled bit.
- Mode effect on a match:
  - cfg_overlap=0 (non-overlapping): fill is forced to 0 on the matching edge. The next match needs L fresh bits.
  - cfg_overlap=1 (overlapping): fill continues to increment/saturate as normal.
- cfg_load:
  - On the edge it is sampled, the config fields are latched, fill is set to 0 and hist is cleared.
  - A bit with a_en=1 on that same edge is discarded and valid=0.
  - Config inputs are ignored when cfg_load=0.
- L=0 or L>PAT_W: detector disabled. valid stays 0; hist and fill still update.
- match_count:
  - Increments on every match and saturates at 2^CNT_W-1.
  - If cnt_clr and a match occur on the same edge, the count becomes 1 (clear, then count).
  - cnt_clr alone sets the count to 0. cnt_clr does not affect hist, fill or valid.
- Reset asserted mid-sequence discards all partial history. After reset the detector is disabled until the first cfg_load.

Optional Feature:
- Macro: SEQ_DETECT_MASK_EN.
- When defined: adds input `cfg_mask` (PAT_W bits), latched on cfg_load and cleared by reset. Position k is don't-care when cfg_mask[k]=1 and is excluded from the compare. Length and fill rules are unchanged.
- When undefined: the port is absent and every position within L is compared.

Test Plan:
1. Reset, then cfg_load with pattern=8'b0000_1101, len=4, overlap=0; stream 1,0,1,1 with a_en=1 -> exactly one valid pulse, one cycle after the 4th bit's edge; match_count=1.
2. Same config; stream 1,0,1,1,0,1,1 -> overlap=0: one pulse (bit 4 only), count=1; reload with overlap=1 and repeat -> pulses after bits 4 and 7, count=2.
3. Pattern 3'b111, len=3, overlap=1; stream six 1s -> pulses after bits 3,4,5,6, count=4; with overlap=0 -> pulses after bits 3 and 6, count=2.
4. len=4 pattern 1,0,1,1; stream 1,0, then a_en=0 for 3 cycles with a toggling, then 1,1 -> one pulse after the final bit; gated cycles leave hist and fill unchanged.
5. CNT_W=2; send 5 matches -> count saturates at 3; cnt_clr coincident with a 6th match -> count=1.
6. Assert reset after 3 of 4 pattern bits, then cfg_load and send only the last bit -> no pulse; len=0 with any stream -> valid never asserts; (with SEQ_DETECT_MASK_EN) mask=4'b0010 -> 1,0,1,1 and 1,1,1,1 both match.
